// File: rtl/uart_reg_slave.sv
// uart_reg_slave: command/response register slave with 8 RW control bytes
// (0x00-0x07 -> ctrl_out) and 8 RO status bytes (0x08-0x0F <- status_in).
// Each command passes IDLE -> (WAIT) -> ACCEPT, and reads add a RESP cycle.
// ACCEPT_WAIT inserts 0-15 wait cycles before the accept pulse.
// Optional feature macro: UART_REG_ERRCNT_EN adds a saturating error
// counter at 0x10 that counts accesses to unmapped addresses.
module uart_reg_slave #(
  parameter int unsigned ACCEPT_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  uart_MCmd,
  input  logic [7:0]  uart_MAddr,
  input  logic [7:0]  uart_MData,
  output logic        uart_SCmdAccept,
  output logic [7:0]  uart_SData,
  output logic [1:0]  uart_SResp,
  output logic [63:0] ctrl_out,
  input  logic [63:0] status_in,
  output logic        wr_stb,
  output logic [2:0]  wr_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCEPT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] CMD_WR    = 3'b001;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;
  // Counter preload; a zero wait never enters WAIT, so the value is unused then.
  localparam logic [3:0] WAIT_LOAD = (ACCEPT_WAIT > 0) ? 4'(ACCEPT_WAIT - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept_q, accept_d;
  logic        wr_stb_q, wr_stb_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [63:0] ctrl_q, ctrl_d;
  logic [1:0]  resp_q, resp_d;
  logic [7:0]  sdata_q, sdata_d;
  // Read result captured at the accept edge, presented in the RESP cycle.
  logic        pend_rd_q, pend_rd_d;
  logic [1:0]  pend_resp_q, pend_resp_d;
  logic [7:0]  pend_data_q, pend_data_d;
`ifdef UART_REG_ERRCNT_EN
  logic [7:0]  errcnt_q, errcnt_d;
`endif

  logic        is_wr, is_rd, do_accept;
  logic        addr_rw, addr_ro, addr_unmapped;

  logic [7:0]  ctrl_byte   [8];
  logic [7:0]  status_byte [8];

  // Byte views of the control and status words for the read mux.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    assign ctrl_byte[gi]   = ctrl_q[8*gi +: 8];
    assign status_byte[gi] = status_in[8*gi +: 8];
  end

  assign is_wr   = (uart_MCmd == CMD_WR);
  assign is_rd   = (uart_MCmd == CMD_RD);
  assign addr_rw = (uart_MAddr[7:3] == 5'd0);
  assign addr_ro = (uart_MAddr[7:3] == 5'd1);
`ifdef UART_REG_ERRCNT_EN
  assign addr_unmapped = (uart_MAddr[7:4] != 4'd0) && (uart_MAddr != 8'h10);
`else
  assign addr_unmapped = (uart_MAddr[7:4] != 4'd0);
`endif

  // Next-state logic plus the command side effects committed at the accept edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept_d    = 1'b0;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    ctrl_d      = ctrl_q;
    resp_d      = RESP_NONE;
    sdata_d     = 8'h00;
    pend_rd_d   = pend_rd_q;
    pend_resp_d = pend_resp_q;
    pend_data_d = pend_data_q;
    do_accept   = 1'b0;
`ifdef UART_REG_ERRCNT_EN
    errcnt_d    = errcnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (is_wr || is_rd) begin
          if (ACCEPT_WAIT > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d   = ACCEPT;
            do_accept = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = ACCEPT;
          do_accept = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCEPT: begin
        cnt_d = 4'd0;
        if (pend_rd_q) begin
          state_d = RESP;
          resp_d  = pend_resp_q;
          sdata_d = pend_data_q;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (do_accept) begin
      accept_d    = 1'b1;
      pend_rd_d   = is_rd;
      pend_resp_d = RESP_NONE;
      pend_data_d = 8'h00;
      if (is_wr && addr_rw) begin
        ctrl_d[{uart_MAddr[2:0], 3'b000} +: 8] = uart_MData;
        wr_stb_d  = 1'b1;
        wr_addr_d = uart_MAddr[2:0];
      end
      if (is_rd) begin
        if (addr_rw) begin
          pend_resp_d = RESP_DVA;
          pend_data_d = ctrl_byte[uart_MAddr[2:0]];
        end else if (addr_ro) begin
          pend_resp_d = RESP_DVA;
          pend_data_d = status_byte[uart_MAddr[2:0]];
        end else if (addr_unmapped) begin
          pend_resp_d = RESP_ERR;
        end
`ifdef UART_REG_ERRCNT_EN
        else begin
          pend_resp_d = RESP_DVA;
          pend_data_d = errcnt_q;
        end
`endif
      end
`ifdef UART_REG_ERRCNT_EN
      if (addr_unmapped && (is_wr || is_rd)) begin
        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end else if (is_wr && (uart_MAddr == 8'h10)) begin
        errcnt_d = 8'h00;
      end
`endif
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      accept_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 3'd0;
      ctrl_q      <= 64'd0;
      resp_q      <= RESP_NONE;
      sdata_q     <= 8'h00;
      pend_rd_q   <= 1'b0;
      pend_resp_q <= RESP_NONE;
      pend_data_q <= 8'h00;
`ifdef UART_REG_ERRCNT_EN
      errcnt_q    <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      accept_q    <= accept_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      ctrl_q      <= ctrl_d;
      resp_q      <= resp_d;
      sdata_q     <= sdata_d;
      pend_rd_q   <= pend_rd_d;
      pend_resp_q <= pend_resp_d;
      pend_data_q <= pend_data_d;
`ifdef UART_REG_ERRCNT_EN
      errcnt_q    <= errcnt_d;
`endif
    end
  end

  assign uart_SCmdAccept = accept_q;
  assign uart_SData      = sdata_q;
  assign uart_SResp      = resp_q;
  assign ctrl_out        = ctrl_q;
  assign wr_stb          = wr_stb_q;
  assign wr_addr         = wr_addr_q;

endmodule

// File: tb/tb_uart_reg_slave.sv
// Directed bench for uart_reg_slave: dut0 runs with ACCEPT_WAIT=0 and
// dut3 with ACCEPT_WAIT=3, each with its own command bus and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_reg_slave;

  logic        clk = 1'b0;
  logic        reset0, reset3;
  logic [2:0]  m0_cmd, m3_cmd;
  logic [7:0]  m0_addr, m0_data, m3_addr, m3_data;
  logic        acc0, acc3;
  logic [7:0]  sdata0, sdata3;
  logic [1:0]  sresp0, sresp3;
  logic [63:0] ctrl0, ctrl3, status0, status3;
  logic        wrstb0, wrstb3;
  logic [2:0]  wraddr0, wraddr3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_reg_slave #(.ACCEPT_WAIT(0)) dut0 (
    .clk(clk), .reset(reset0),
    .uart_MCmd(m0_cmd), .uart_MAddr(m0_addr), .uart_MData(m0_data),
    .uart_SCmdAccept(acc0), .uart_SData(sdata0), .uart_SResp(sresp0),
    .ctrl_out(ctrl0), .status_in(status0), .wr_stb(wrstb0), .wr_addr(wraddr0)
  );

  uart_reg_slave #(.ACCEPT_WAIT(3)) dut3 (
    .clk(clk), .reset(reset3),
    .uart_MCmd(m3_cmd), .uart_MAddr(m3_addr), .uart_MData(m3_data),
    .uart_SCmdAccept(acc3), .uart_SData(sdata3), .uart_SResp(sresp3),
    .ctrl_out(ctrl3), .status_in(status3), .wr_stb(wrstb3), .wr_addr(wraddr3)
  );

  // One-cycle command on dut0: returns accept seen in the next cycle and
  // the response seen in the cycle after that.
  task automatic xfer0(input logic [2:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                       output logic acc, output logic [1:0] resp, output logic [7:0] rdata);
    @(negedge clk);
    m0_cmd = cmd; m0_addr = addr; m0_data = data;
    @(negedge clk);
    acc = acc0;
    m0_cmd = 3'b000;
    @(negedge clk);
    resp = sresp0;
    rdata = sdata0;
    $display("txn dut0 cmd=%b addr=%h data=%h -> acc=%b resp=%b sdata=%h", cmd, addr, data, acc, resp, rdata);
  endtask

  task automatic test_reset();
    reset0 = 1'b1; reset3 = 1'b1;
    m0_cmd = 3'b000; m0_addr = 8'h00; m0_data = 8'h00;
    m3_cmd = 3'b000; m3_addr = 8'h00; m3_data = 8'h00;
    status0 = 64'h8877_6655_4433_2211;
    status3 = 64'h0000_0000_0000_C300;
    repeat (3) @(negedge clk);
    reset0 = 1'b0; reset3 = 1'b0;
    @(negedge clk);
    checks++; if (acc0 !== 1'b0)   begin errors++; $display("FAIL reset_acc0 got=%b exp=0", acc0); end
    checks++; if (sresp0 !== 2'b00) begin errors++; $display("FAIL reset_sresp0 got=%b exp=00", sresp0); end
    checks++; if (sdata0 !== 8'h00) begin errors++; $display("FAIL reset_sdata0 got=%h exp=00", sdata0); end
    checks++; if (ctrl0 !== 64'd0)  begin errors++; $display("FAIL reset_ctrl0 got=%h exp=0", ctrl0); end
    checks++; if (wrstb0 !== 1'b0 || wraddr0 !== 3'd0) begin errors++; $display("FAIL reset_wr0 got=%b/%0d exp=0/0", wrstb0, wraddr0); end
    checks++; if (acc3 !== 1'b0 || ctrl3 !== 64'd0) begin errors++; $display("FAIL reset_dut3 got=%b/%h exp=0/0", acc3, ctrl3); end
    $display("txn reset released");
  endtask

  task automatic test_write();
    @(negedge clk);
    m0_cmd = 3'b001; m0_addr = 8'h02; m0_data = 8'h5A;
    @(negedge clk);
    checks++; if (acc0 !== 1'b1)    begin errors++; $display("FAIL wr_accept got=%b exp=1", acc0); end
    checks++; if (wrstb0 !== 1'b1)  begin errors++; $display("FAIL wr_stb got=%b exp=1", wrstb0); end
    checks++; if (wraddr0 !== 3'd2) begin errors++; $display("FAIL wr_addr got=%0d exp=2", wraddr0); end
    checks++; if (ctrl0[23:16] !== 8'h5A) begin errors++; $display("FAIL wr_ctrl got=%h exp=5a", ctrl0[23:16]); end
    checks++; if (sresp0 !== 2'b00) begin errors++; $display("FAIL wr_sresp got=%b exp=00", sresp0); end
    m0_cmd = 3'b000;
    @(negedge clk);
    checks++; if (acc0 !== 1'b0 || wrstb0 !== 1'b0) begin errors++; $display("FAIL wr_pulse_end got=%b/%b exp=0/0", acc0, wrstb0); end
    checks++; if (sresp0 !== 2'b00) begin errors++; $display("FAIL wr_noresp got=%b exp=00", sresp0); end
    checks++; if (ctrl0 !== 64'h0000_0000_005A_0000) begin errors++; $display("FAIL wr_ctrl_full got=%h exp=5a0000", ctrl0); end
    $display("txn dut0 write 02=5a");
  endtask

  task automatic test_read();
    @(negedge clk);
    m0_cmd = 3'b010; m0_addr = 8'h02; m0_data = 8'h00;
    @(negedge clk);
    checks++; if (acc0 !== 1'b1)    begin errors++; $display("FAIL rd_accept got=%b exp=1", acc0); end
    checks++; if (sresp0 !== 2'b00) begin errors++; $display("FAIL rd_early_resp got=%b exp=00", sresp0); end
    m0_cmd = 3'b000;
    @(negedge clk);
    checks++; if (sresp0 !== 2'b01) begin errors++; $display("FAIL rd_resp got=%b exp=01", sresp0); end
    checks++; if (sdata0 !== 8'h5A) begin errors++; $display("FAIL rd_data got=%h exp=5a", sdata0); end
    checks++; if (acc0 !== 1'b0)    begin errors++; $display("FAIL rd_acc_end got=%b exp=0", acc0); end
    @(negedge clk);
    checks++; if (sresp0 !== 2'b00 || sdata0 !== 8'h00) begin errors++; $display("FAIL rd_resp_end got=%b/%h exp=00/00", sresp0, sdata0); end
    checks++; if (wraddr0 !== 3'd2) begin errors++; $display("FAIL rd_wraddr_hold got=%0d exp=2", wraddr0); end
    $display("txn dut0 read 02");
  endtask

  task automatic test_wait_read();
    @(negedge clk);
    m3_cmd = 3'b010; m3_addr = 8'h09; m3_data = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (acc3 !== 1'b0) begin errors++; $display("FAIL wait_early_acc cycle=%0d got=%b exp=0", i, acc3); end
    end
    @(negedge clk);
    checks++; if (acc3 !== 1'b1) begin errors++; $display("FAIL wait_accept got=%b exp=1", acc3); end
    m3_cmd = 3'b000;
    status3 = 64'd0;
    @(negedge clk);
    checks++; if (sresp3 !== 2'b01) begin errors++; $display("FAIL wait_resp got=%b exp=01", sresp3); end
    checks++; if (sdata3 !== 8'hC3) begin errors++; $display("FAIL wait_data got=%h exp=c3", sdata3); end
    @(negedge clk);
    checks++; if (sresp3 !== 2'b00) begin errors++; $display("FAIL wait_resp_end got=%b exp=00", sresp3); end
    $display("txn dut3 read 09");
  endtask

  task automatic test_unmapped();
    logic a; logic [1:0] r; logic [7:0] d;
    xfer0(3'b010, 8'h40, 8'h00, a, r, d);
    checks++; if (a !== 1'b1)    begin errors++; $display("FAIL unm_accept got=%b exp=1", a); end
    checks++; if (r !== 2'b11)   begin errors++; $display("FAIL unm_resp got=%b exp=11", r); end
    checks++; if (d !== 8'h00)   begin errors++; $display("FAIL unm_data got=%h exp=00", d); end
`ifdef UART_REG_ERRCNT_EN
    xfer0(3'b010, 8'h10, 8'h00, a, r, d);
    checks++; if (r !== 2'b01 || d !== 8'h01) begin errors++; $display("FAIL errcnt_one got=%b/%h exp=01/01", r, d); end
    xfer0(3'b001, 8'h10, 8'h77, a, r, d);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL errcnt_wr_resp got=%b exp=00", r); end
    xfer0(3'b010, 8'h10, 8'h00, a, r, d);
    checks++; if (r !== 2'b01 || d !== 8'h00) begin errors++; $display("FAIL errcnt_clear got=%b/%h exp=01/00", r, d); end
`else
    xfer0(3'b010, 8'h10, 8'h00, a, r, d);
    checks++; if (r !== 2'b11 || d !== 8'h00) begin errors++; $display("FAIL addr10_unmapped got=%b/%h exp=11/00", r, d); end
`endif
  endtask

  task automatic test_ro_drop();
    logic a; logic [1:0] r; logic [7:0] d;
    xfer0(3'b001, 8'h09, 8'h11, a, r, d);
    checks++; if (a !== 1'b1 || r !== 2'b00) begin errors++; $display("FAIL ro_wr got=%b/%b exp=1/00", a, r); end
    checks++; if (ctrl0 !== 64'h0000_0000_005A_0000 || wraddr0 !== 3'd2) begin errors++; $display("FAIL ro_wr_dropped got=%h/%0d exp=5a0000/2", ctrl0, wraddr0); end
    xfer0(3'b010, 8'h0F, 8'h00, a, r, d);
    checks++; if (r !== 2'b01 || d !== 8'h88) begin errors++; $display("FAIL ro_rd got=%b/%h exp=01/88", r, d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    m0_cmd = 3'b001; m0_addr = 8'h03; m0_data = 8'hAA;
    @(negedge clk);
    checks++; if (acc0 !== 1'b1) begin errors++; $display("FAIL b2b_acc1 got=%b exp=1", acc0); end
    m0_addr = 8'h04; m0_data = 8'hBB;
    @(negedge clk);
    checks++; if (acc0 !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", acc0); end
    @(negedge clk);
    checks++; if (acc0 !== 1'b1 || wrstb0 !== 1'b1 || wraddr0 !== 3'd4) begin errors++; $display("FAIL b2b_acc2 got=%b/%b/%0d exp=1/1/4", acc0, wrstb0, wraddr0); end
    checks++; if (ctrl0[39:24] !== 16'hBBAA) begin errors++; $display("FAIL b2b_ctrl got=%h exp=bbaa", ctrl0[39:24]); end
    m0_cmd = 3'b000;
    @(negedge clk);
    $display("txn dut0 back-to-back writes 03=aa 04=bb");
  endtask

  task automatic test_abort();
    @(negedge clk);
    m3_cmd = 3'b001; m3_addr = 8'h01; m3_data = 8'h77;
    @(negedge clk);
    reset3 = 1'b1;
    m3_cmd = 3'b000;
    @(negedge clk);
    reset3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (acc3 !== 1'b0 || ctrl3 !== 64'd0 || wrstb3 !== 1'b0) begin errors++; $display("FAIL abort cycle=%0d got=%b/%h/%b exp=0/0/0", i, acc3, ctrl3, wrstb3); end
      @(negedge clk);
    end
    $display("txn dut3 write 01 aborted by reset");
  endtask

  task automatic test_illegal_cmd();
    @(negedge clk);
    m0_cmd = 3'b011; m0_addr = 8'h05; m0_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) m0_cmd = 3'b111;
      checks++; if (acc0 !== 1'b0 || wrstb0 !== 1'b0 || sresp0 !== 2'b00) begin errors++; $display("FAIL illegal_cmd cycle=%0d got=%b/%b/%b exp=0/0/00", i, acc0, wrstb0, sresp0); end
    end
    m0_cmd = 3'b000;
    checks++; if (ctrl0[47:40] !== 8'h00) begin errors++; $display("FAIL illegal_ctrl got=%h exp=00", ctrl0[47:40]); end
    $display("txn dut0 illegal commands 011/111");
  endtask

  task automatic test_reset_clears();
    logic a; logic [1:0] r; logic [7:0] d;
    @(negedge clk);
    reset0 = 1'b1;
    @(negedge clk);
    reset0 = 1'b0;
    checks++; if (ctrl0 !== 64'd0 || wraddr0 !== 3'd0) begin errors++; $display("FAIL rst_clear got=%h/%0d exp=0/0", ctrl0, wraddr0); end
    xfer0(3'b010, 8'h03, 8'h00, a, r, d);
    checks++; if (r !== 2'b01 || d !== 8'h00) begin errors++; $display("FAIL rst_readback got=%b/%h exp=01/00", r, d); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_read();
    test_unmapped();
    test_ro_drop();
    test_back_to_back();
    test_abort();
    test_illegal_cmd();
    test_reset_clears();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
